// File: rtl/uart_tx_path_if.sv
// rtl/uart_tx_path_if.sv - control, push and status signals between the UART register block and the TX path
interface uart_tx_path_if;
    logic       uart_en;
    logic       baud_sel;
    logic       wr_txfifo;
    logic [7:0] wrdata;
    logic       txd;
    logic       tx_flag;
    logic       txfifo_empty;
    logic       txfifo_full;
    logic       tx_busy;
    logic       tx_ovf;

    modport master (
        output uart_en, baud_sel, wr_txfifo, wrdata,
        input  txd, tx_flag, txfifo_empty, txfifo_full, tx_busy, tx_ovf
    );

    modport slave (
        input  uart_en, baud_sel, wr_txfifo, wrdata,
        output txd, tx_flag, txfifo_empty, txfifo_full, tx_busy, tx_ovf
    );
endinterface

// File: rtl/uart_tx_path.sv
// rtl/uart_tx_path.sv - UART transmit path: byte FIFO feeding an 8N1 serialiser
module uart_tx_path #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int DIV_SLOW = 5208,
    parameter int DIV_FAST = 434,
    parameter int CW       = 13
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    uart_tx_path_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0] r_count;
    logic        r_empty, r_full, r_ovf;

    state_t      r_state;
    logic [7:0]  r_sh;
    logic [CW-1:0] r_div, r_cnt;
    logic [2:0]  r_idx;
    logic        r_txd, r_flag, r_busy;

    logic        w_pop, w_push, w_drop, w_bit_end;
    logic [AW:0] w_count_nxt;

    assign w_pop     = (r_state == S_IDLE) && bus.uart_en && !r_empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign w_push    = bus.wr_txfifo && (!r_full || w_pop);
    assign w_drop    = bus.wr_txfifo && r_full && !w_pop;
    assign w_bit_end = (r_cnt == r_div - 1'b1);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (w_push) r_mem[r_wptr] <= bus.wrdata;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_ovf   <= w_drop;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_txd   <= 1'b1;
            r_flag  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (r_state != S_IDLE && !bus.uart_en) begin
            // Abort: the byte in flight is dropped, tx_flag keeps its value.
            r_state <= S_IDLE;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_sh    <= r_mem[r_rptr];
                        r_div   <= bus.baud_sel ? CW'(DIV_FAST) : CW'(DIV_SLOW);
                        r_cnt   <= '0;
                        r_flag  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_txd   <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_txd   <= r_sh[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        r_sh  <= r_sh >> 1;
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_txd <= r_sh[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_flag  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.txd          = r_txd;
    assign bus.tx_flag      = r_flag;
    assign bus.txfifo_empty = r_empty;
    assign bus.txfifo_full  = r_full;
    assign bus.tx_busy      = r_busy;
    assign bus.tx_ovf       = r_ovf;
endmodule

// File: tb/tb_uart_tx_path.sv
// tb/tb_uart_tx_path.sv - directed and randomized bench for uart_tx_path with a serial-frame reference model
module tb_uart_tx_path;
    localparam int DS = 16;
    localparam int DF = 4;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;

    uart_tx_path_if u_if ();

    uart_tx_path #(
        .DEPTH(16), .AW(4), .DIV_SLOW(DS), .DIV_FAST(DF), .CW(5)
    ) u_dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (u_if.slave)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;
    byte unsigned exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input byte unsigned b);
        u_if.wr_txfifo = 1'b1;
        u_if.wrdata    = b;
        @(negedge PCLK);
        u_if.wr_txfifo = 1'b0;
    endtask

    task automatic wait_start(input int max);
        int n = 0;
        while (u_if.txd !== 1'b0 && n < max) begin
            @(negedge PCLK);
            n++;
        end
        chk("start_seen", u_if.txd, 0);
    endtask

    // Called at the first low sample of a start bit; ends one sample after the stop bit
    // (or at the next start bit when another frame is expected).
    task automatic check_frame(input int div, input bit more);
        byte unsigned e_byte;
        byte unsigned got;
        int nbad;
        int k;
        logic bitv;
        nbad = 0;
        got  = 0;
        chk("model_nonempty", exp_q.size() != 0, 1);
        e_byte = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        for (int t = 0; t < 10*div; t++) begin
            k = t / div;
            bitv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : e_byte[k-1];
            if (u_if.txd !== bitv) nbad++;
            if ((t % div) == div/2 && k >= 1 && k <= 8) got[k-1] = u_if.txd;
            @(negedge PCLK);
        end
        chk("frame_wave", nbad, 0);
        chk("frame_byte", got, e_byte);
        chk("flag_end", u_if.tx_flag, 1);
        chk("busy_end", u_if.tx_busy, 0);
        chk("txd_end", u_if.txd, 1);
        if (more) begin
            @(negedge PCLK);
            chk("gap_txd", u_if.txd, 0);
            chk("gap_flag", u_if.tx_flag, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned b;
        int n;
        int lows;
        bit bs;

        u_if.uart_en   = 1'b0;
        u_if.baud_sel  = 1'b0;
        u_if.wr_txfifo = 1'b0;
        u_if.wrdata    = 8'h00;

        // Reset values
        repeat (2) @(negedge PCLK);
        chk("rst_txd", u_if.txd, 1);
        chk("rst_empty", u_if.txfifo_empty, 1);
        chk("rst_full", u_if.txfifo_full, 0);
        chk("rst_flag", u_if.tx_flag, 0);
        chk("rst_busy", u_if.tx_busy, 0);
        chk("rst_ovf", u_if.tx_ovf, 0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Single byte, fast rate, exact pop latency
        u_if.uart_en  = 1'b1;
        u_if.baud_sel = 1'b1;
        exp_q.push_back(8'hA5);
        push(8'hA5);
        chk("single_pre_txd", u_if.txd, 1);
        chk("single_pre_empty", u_if.txfifo_empty, 0);
        @(negedge PCLK);
        chk("single_fall", u_if.txd, 0);
        chk("single_busy", u_if.tx_busy, 1);
        chk("single_empty", u_if.txfifo_empty, 1);
        check_frame(DF, 1'b0);

        // Back-to-back frames, slow rate
        u_if.uart_en  = 1'b0;
        u_if.baud_sel = 1'b0;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(8'h00); push(8'h00);
        exp_q.push_back(8'hFF); push(8'hFF);
        exp_q.push_back(8'h3C); push(8'h3C);
        u_if.uart_en = 1'b1;
        wait_start(10);
        for (int i = 0; i < 3; i++) check_frame(DS, i < 2);
        chk("b2b_empty", u_if.txfifo_empty, 1);

        // Overflow with the transmitter disabled
        u_if.uart_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("ovf_full_at15", u_if.txfifo_full, 0);
            b = 8'($urandom);
            exp_q.push_back(b);
            push(b);
        end
        chk("ovf_full_at16", u_if.txfifo_full, 1);
        chk("ovf_no_pulse_yet", u_if.tx_ovf, 0);
        push(8'($urandom));
        chk("ovf_pulse", u_if.tx_ovf, 1);
        @(negedge PCLK);
        chk("ovf_pulse_end", u_if.tx_ovf, 0);
        chk("ovf_still_full", u_if.txfifo_full, 1);
        u_if.baud_sel = 1'b1;
        u_if.uart_en  = 1'b1;
        wait_start(10);
        for (int i = 0; i < 16; i++) check_frame(DF, i < 15);
        chk("ovf_drained", u_if.txfifo_empty, 1);

        // Push coinciding with a pop while full
        u_if.uart_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            push(b);
        end
        b = 8'($urandom);
        exp_q.push_back(b);
        u_if.uart_en = 1'b1;
        push(b);
        chk("pp_no_ovf", u_if.tx_ovf, 0);
        chk("pp_full", u_if.txfifo_full, 1);
        wait_start(10);
        for (int i = 0; i < 17; i++) check_frame(DF, i < 16);
        chk("pp_drained", u_if.txfifo_empty, 1);

        // Abort during data bit 3
        b = 8'($urandom);
        push(b);
        @(negedge PCLK);
        chk("abort_started", u_if.txd, 0);
        repeat (17) @(negedge PCLK);
        chk("abort_bit3", u_if.txd, b[3]);
        u_if.uart_en = 1'b0;
        @(negedge PCLK);
        chk("abort_txd", u_if.txd, 1);
        chk("abort_busy", u_if.tx_busy, 0);
        chk("abort_flag", u_if.tx_flag, 0);
        lows = 0;
        repeat (40) begin
            @(negedge PCLK);
            if (u_if.txd !== 1'b1) lows++;
        end
        chk("abort_quiet", lows, 0);
        chk("abort_empty", u_if.txfifo_empty, 1);

        // Baud change mid-frame applies to the next frame only
        b = 8'($urandom); exp_q.push_back(b); push(b);
        b = 8'($urandom); exp_q.push_back(b); push(b);
        u_if.baud_sel = 1'b1;
        u_if.uart_en  = 1'b1;
        wait_start(10);
        u_if.baud_sel = 1'b0;
        check_frame(DF, 1'b1);
        check_frame(DS, 1'b0);

        // Randomized bursts
        for (int r = 0; r < 3; r++) begin
            u_if.uart_en = 1'b0;
            bs = 1'($urandom_range(0, 1));
            u_if.baud_sel = bs;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                push(b);
            end
            u_if.uart_en = 1'b1;
            wait_start(10);
            for (int i = 0; i < n; i++) check_frame(bs ? DF : DS, i < n - 1);
        end
        chk("final_empty", u_if.txfifo_empty, 1);
        chk("final_model_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_path.md
Name: uart_tx_path

Overview:
- Transmit half of the UART core, directly downstream of the APB UART register block.
- Accepts byte writes (write strobe plus data from the DR write path), buffers them in a TX FIFO and serialises them onto TXD as 8N1 frames, LSB first.
- Returns the TX status bits consumed by the status register: FIFO empty and TX-done flag.
- Baud timing is generated internally from PCLK using two selectable divisors.

Parameters:
- DEPTH, 16, TX FIFO depth in bytes; power of 2, 2..256.
- AW, 4, FIFO pointer width; log2(DEPTH).
- DIV_SLOW, 5208, PCLK cycles per bit when baud_sel=0 (50 MHz / 9600).
- DIV_FAST, 434, PCLK cycles per bit when baud_sel=1 (50 MHz / 115200).
- CW, 13, width of the bit-period counter; must satisfy 2^CW > max(DIV_SLOW, DIV_FAST).

Ports:
- PCLK  input  1  system clock.
- PRESETn  input  1  asynchronous, active-low reset.
- uart_en  input  1  transmitter enable (CR[0]).
- baud_sel  input  1  divisor select (CR[1]): 0 selects DIV_SLOW, 1 selects DIV_FAST.
- wr_txfifo  input  1  one-cycle push strobe.
- wrdata  input  8  byte to push; sampled when wr_txfifo=1.
- txd  output  1  serial output; idle level is 1.
- tx_flag  output  1  frame-complete flag, level (SR[1]).
- txfifo_empty  output  1  FIFO holds 0 bytes (SR[3]).
- txfifo_full  output  1  FIFO holds DEPTH bytes.
- tx_busy  output  1  high while a frame is in flight.
- tx_ovf  output  1  one-cycle pulse when a push is dropped.

Behaviour:
Reset (asynchronous):
- txd=1, tx_flag=0, txfifo_empty=1, txfifo_full=0, tx_busy=0, tx_ovf=0.
- FIFO pointers and count=0; FSM in IDLE; bit counter=0.

FIFO:
- Synchronous write/read pointers plus a count register of width AW+1.
- Flags are registered and derived from the next-state count.
- Push when wr_txfifo=1 and not full.
- Push while full and no pop that cycle: byte dropped, tx_ovf=1 for 1 cycle, FIFO unchanged.
- Push while full with a pop in the same cycle: push accepted, count unchanged.
- Pointers wrap modulo DEPTH.
- FIFO contents are retained regardless of uart_en.

FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - txd=1.
  - If uart_en=1 and FIFO not empty: pop the head byte into shift register sh[7:0], latch the divisor selected by baud_sel into div_q, clear the bit counter, clear tx_flag, set tx_busy, go to START.
  - txd falls on the cycle after the pop (1-cycle latency).
- START:
  - txd=0 for div_q cycles, then go to DATA with bit index=0.
- DATA:
  - txd=sh[0] for div_q cycles per bit.
  - At the end of each bit: shift sh right, increment the index.
  - After index 7 completes, go to STOP.
- STOP:
  - txd=1 for div_q cycles.
  - At the end: tx_flag=1, tx_busy=0, go to IDLE.
  - If the FIFO is not empty and uart_en=1, the next pop occurs in the IDLE cycle that follows.
  - Inter-frame gap is exactly 1 PCLK cycle.

Bit counter:
- Counts 0..div_q-1.
- The bit-end strobe fires at count div_q-1; the counter then reloads to 0.

Frame length: 10*div_q PCLK cycles from the start-bit falling edge to the end of the stop bit.

baud_sel:
- Sampled only at the pop.
- A change mid-frame takes effect from the next frame.

uart_en:
- Deassertion mid-frame aborts the frame: next cycle txd=1, state=IDLE, tx_busy=0, tx_flag unchanged; the byte in flight is discarded.
- uart_en=0 in IDLE: no pops, pushes still accepted.

tx_flag:
- Stays high until the next frame starts (pop) or reset.

Output registering: txd and all flags are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset check with DIV_FAST=4, DIV_SLOW=16: hold PRESETn=0 -> txd=1, txfifo_empty=1, txfifo_full=0, tx_flag=0, tx_busy=0.
- Single byte, uart_en=1, baud_sel=1, push 0xA5 -> txd falls 1 cycle after pop; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop=1; frame length 40 cycles; tx_flag rises at frame end; txfifo_empty returns to 1.
- Back-to-back, baud_sel=0, push 0x00,0xFF,0x3C -> three frames of 160 cycles each, separated by 1-cycle idle gaps; tx_flag drops at each pop and rises after each frame; decoded bytes 0x00,0xFF,0x3C.
- Overflow, uart_en=0, DEPTH=16: push 17 bytes -> txfifo_full=1 after the 16th push; the 17th push gives a tx_ovf pulse; after enabling, exactly 16 bytes are transmitted in order.
- Full with simultaneous push/pop, uart_en=1: push so a pop coincides with a push at count=16 -> count stays 16, no tx_ovf, and the new byte is transmitted last.
- Abort and baud change: clear uart_en during DATA bit 3 -> txd=1 the next cycle, tx_busy=0. Toggle baud_sel mid-frame -> the current frame keeps the old rate and the next frame uses the new rate.
